// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetches under a credit limit, buffers the
// returned words in an in-order prefetch queue, and flushes on branch redirect.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, head_pc, redirect_aligned;
    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count, outstanding, drop_cnt, drop_nxt;
    logic [CW:0]       inflight;
    logic              req_fire, push, pop;

    // Slots already claimed: queued words plus responses that will actually be kept.
    assign inflight         = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop_cnt};
    assign imem_req_valid   = !redirect_valid && (inflight < DEPTH_W);
    assign imem_req_addr    = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    assign dec_valid = (count != '0);
    assign dec_instr = mem[head];
    assign dec_pc    = head_pc;

    assign push = imem_rsp_valid && (state == RUN) && !redirect_valid;
    assign pop  = dec_valid && dec_ready;

    always_comb begin
        drop_nxt = drop_cnt;
        if (redirect_valid)
            drop_nxt = outstanding - CW'(imem_rsp_valid);
        else if (imem_rsp_valid && state == FLUSH)
            drop_nxt = drop_cnt - CW'(1);
        state_nxt = (drop_nxt != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            drop_cnt    <= drop_nxt;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                head_pc  <= redirect_aligned;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
                if (push) begin
                    mem[tail] <= imem_rsp_data;
                    tail      <= tail + 1'b1;
                end
                if (pop) begin
                    head    <= head + 1'b1;
                    head_pc <= head_pc + ADDR_W'(4);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && !pop && count == DEPTH_C));
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a variable-latency in-order memory model,
// a table of per-cycle vectors for plain streaming, and hand sequences for corners.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        logic dec_rdy; logic req_rdy;
        logic exp_rv; logic [31:0] exp_addr;
        logic exp_dv; logic [31:0] exp_pc; logic [31:0] exp_instr;
    } vec_t;

    mreq_t mq[$];
    vec_t  vecs[6];
    int    cyc = 0, lat = 1, n_chk = 0, n_fail = 0, fires = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory words are 0x1300_0000 | address.
    task automatic tick();
        if (!reset) begin
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + lat});
                fires++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (reset) mq.delete();
        imem_rsp_valid = !reset && mq.size() > 0 && mq[0].due <= cyc;
        imem_rsp_data  = imem_rsp_valid ? (32'h1300_0000 | mq[0].addr) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        dec_ready = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        mq.delete();
        #1;
        chk("rst dec_valid", dec_valid, 0);
        chk("rst dec_pc", dec_pc, 32'h0);
        chk("rst dec_instr", dec_instr, 32'h0);
        chk("rst req_addr", imem_req_addr, 32'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 6; i++) begin
            dec_ready = vecs[i].dec_rdy; imem_req_ready = vecs[i].req_rdy; #1;
            chk($sformatf("%s c%0d req_valid", tag, i), imem_req_valid, vecs[i].exp_rv);
            chk($sformatf("%s c%0d req_addr", tag, i), imem_req_addr, vecs[i].exp_addr);
            chk($sformatf("%s c%0d dec_valid", tag, i), dec_valid, vecs[i].exp_dv);
            chk($sformatf("%s c%0d dec_pc", tag, i), dec_pc, vecs[i].exp_pc);
            chk($sformatf("%s c%0d dec_instr", tag, i), dec_instr, vecs[i].exp_instr);
            tick();
        end
    endtask

    initial begin
        // 1-cycle memory, decode always ready: streaming after reset.
        vecs[0] = '{1, 1, 1, 32'h00, 0, 32'h0, 32'h0};
        vecs[1] = '{1, 1, 1, 32'h04, 0, 32'h0, 32'h0};
        vecs[2] = '{1, 1, 1, 32'h08, 1, 32'h0, 32'h1300_0000};
        vecs[3] = '{1, 1, 1, 32'h0C, 1, 32'h4, 32'h1300_0004};
        vecs[4] = '{1, 1, 1, 32'h10, 1, 32'h8, 32'h1300_0008};
        vecs[5] = '{1, 1, 1, 32'h14, 1, 32'hC, 32'h1300_000C};

        @(negedge clk);
        lat = 1;
        do_reset();
        run_table("s1");

        // Decode stalled: credit limit stops fetch at 4, then drains and resumes.
        lat = 1;
        do_reset();
        dec_ready = 1'b0; imem_req_ready = 1'b1; #1;
        fires = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("s2 fires", fires, 4);
        chk("s2 req_valid full", imem_req_valid, 0);
        chk("s2 dec_valid full", dec_valid, 1);
        dec_ready = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s2 pop%0d valid", i), dec_valid, 1);
            chk($sformatf("s2 pop%0d pc", i), dec_pc, 32'(i * 4));
            chk($sformatf("s2 pop%0d instr", i), dec_instr, 32'h1300_0000 | 32'(i * 4));
            if (i == 0) chk("s2 still full", imem_req_valid, 0);
            if (i == 1) begin
                chk("s2 resume valid", imem_req_valid, 1);
                chk("s2 resume addr", imem_req_addr, 32'h10);
            end
            tick();
        end

        // Memory not ready: address holds, nothing comes back.
        lat = 1;
        do_reset();
        dec_ready = 1'b1; imem_req_ready = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s3 stall%0d addr", i), imem_req_addr, 32'h0);
            chk($sformatf("s3 stall%0d dec_valid", i), dec_valid, 0);
            tick();
        end
        imem_req_ready = 1'b1; #1;
        tick(); tick();
        chk("s3 first dec_valid", dec_valid, 1);
        chk("s3 first dec_pc", dec_pc, 32'h0);
        chk("s3 first instr", dec_instr, 32'h1300_0000);

        // 3-cycle memory, redirect with two responses owed.
        lat = 3;
        do_reset();
        dec_ready = 1'b1; imem_req_ready = 1'b1; #1;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        chk("s4 no req on redirect", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0; #1;
        chk("s4 target addr", imem_req_addr, 32'h100);
        chk("s4 req in flush", imem_req_valid, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s4 drop%0d dec_valid", i), dec_valid, 0);
            tick();
        end
        chk("s4 dec_valid", dec_valid, 1);
        chk("s4 dec_pc", dec_pc, 32'h100);
        chk("s4 dec_instr", dec_instr, 32'h1300_0100);
        tick();
        chk("s4 next pc", dec_pc, 32'h104);
        chk("s4 next instr", dec_instr, 32'h1300_0104);

        // Redirect coinciding with the only owed response.
        lat = 1;
        do_reset();
        dec_ready = 1'b1; imem_req_ready = 1'b1; #1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("s5 rsp present", imem_rsp_valid, 1);
        chk("s5 no req on redirect", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0; #1;
        chk("s5 req_valid", imem_req_valid, 1);
        chk("s5 target addr", imem_req_addr, 32'h200);
        chk("s5 dropped", dec_valid, 0);
        tick();
        chk("s5 no bypass", dec_valid, 0);
        tick();
        chk("s5 dec_valid", dec_valid, 1);
        chk("s5 dec_pc", dec_pc, 32'h200);
        chk("s5 dec_instr", dec_instr, 32'h1300_0200);

        // Reset mid-operation: 3 queued, 1 outstanding.
        lat = 1;
        do_reset();
        dec_ready = 1'b0; imem_req_ready = 1'b1; #1;
        for (int i = 0; i < 4; i++) tick();
        chk("s6 queued head", dec_pc, 32'h0);
        chk("s6 queued valid", dec_valid, 1);
        do_reset();
        run_table("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
